multicycle_control: RTL and testbench
=====================================

# multicycle_control

Control unit for the 8-bit multicycle RISC-V core (RV32I subset: lw, sw, R-type add/sub/and/or/slt, addi, beq, jal). It is a Moore FSM that sequences the shared ALU, register file and unified memory across fetch, decode, execute, memory and writeback. It waits on a memory ready handshake, can be frozen by an enable input, and halts on unsupported opcodes. State and a retired-instruction counter are exported for the LCD spy interface.

## Interface
- NBITS, 8, width of instret counter
- clock  in  1  core clock
- reset  in  1  synchronous, active-low (reset==0 resets)
- enable  in  1  1: FSM advances; 0: state frozen, all write enables 0
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  0: PC, 1: ALUOut
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A
- ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- state  out  4  current state encoding (LCD)
- halted  out  1  1 in HALT
- instret  out  NBITS  instructions fetched, wraps

## Operation
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 15.
- FETCH: AdrSrc 0, A=PC, B=4, add, ResultSrc 10. IRWrite=PCWrite=mem_ready. Go to DECODE when mem_ready=1, else stay.
- DECODE: A=OldPC, B=Imm, add. Next by opcode: 0000011/0100011→MEMADR, 0110011→EXECUTER, 0010011→EXECUTEI, 1100011→BEQ, 1101111→JAL, any other→HALT.
- MEMADR: A=reg, B=Imm, add. Next: MEMREAD if opcode[5]=0, MEMWRITE if 1.
- MEMREAD: AdrSrc 1. Go to MEMWB on mem_ready, else stay.
- MEMWB: ResultSrc 01, RegWrite 1. Next FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1 held until mem_ready. Next FETCH on mem_ready.
- EXECUTER/EXECUTEI: A=reg, B=reg/Imm, ALU decode (below). Next ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1. Next FETCH.
- BEQ: A=reg, B=reg, sub, ResultSrc 00, PCWrite=Zero. Next FETCH.
- JAL: A=OldPC, B=4, add, ResultSrc 00, PCWrite 1. Next ALUWB.
- HALT: all enables 0. Left only by reset.
- ALU decode in EXECUTER/EXECUTEI by funct3:
  - 000: sub if opcode[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - other funct3: add
- ImmSrc is combinational from opcode in every state; unknown opcode gives 00.
- Unlisted outputs are 0 in each state.
- instret increments by 1 on each cycle where IRWrite=1, wrapping 2^NBITS-1→0.

## Timing
- All outputs except state, halted and instret are combinational from state and inputs (Moore plus mem_ready/Zero gating). There is no added latency.
- Reset: while reset==0, at each clock edge the state loads FETCH and instret loads 0. Combinationally during reset, PCWrite, IRWrite, RegWrite and MemWrite are 0. reset has priority over enable.
- enable=0: state and instret hold, and all four write enables are 0. Mux selects still reflect the state. Resuming continues from the same state, including mid-wait.
- Cycles per instruction with mem_ready constantly 1:
  - lw: 5
  - sw, R-type, addi, jal: 4
  - beq: 3
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- Reset mid-MEMWRITE drops MemWrite in the same cycle reset is sampled low.

## Test plan
- Reset then a stream of R-type add (0x00208033), mem_ready=1 → states 0,1,6,8 repeating. RegWrite is high only in state 8. instret=3 after 12 cycles.
- lw (opcode 0000011) with mem_ready low for 2 cycles in MEMREAD → sequence 0,1,2,3,3,3,4,0. AdrSrc=1 in state 3. RegWrite pulses once with ResultSrc=01.
- beq with Zero=1, then with Zero=0 → PCWrite=1 in state 9 for the first case, 0 for the second. ALUControl=001 in both. 3 cycles each.
- sub R-type (funct7b5=1, funct3=000) gives ALUControl=001. addi with instr[30]=1 gives 000. funct3 111/110/010 give 010/011/101.
- Opcode 0x7F → DECODE→HALT, halted=1, all enables 0 for 20 cycles. reset=0 for one cycle → FETCH, instret=0.
- enable=0 during MEMWRITE with mem_ready=1 → state holds at 5 and MemWrite=0. enable=1 → MemWrite=1, then FETCH.
- 256 fetches with NBITS=8 → instret wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Control unit for the 8-bit multicycle RV32I-subset core.
// Moore FSM sequencing the shared ALU, register file and unified memory
// through fetch/decode/execute/memory/writeback, with a memory-ready
// handshake, a freeze enable, a halt on unsupported opcodes and a wrapping
// retired-instruction counter exported for the LCD spy port.
module multicycle_control #(
  parameter int NBITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [NBITS-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Opcode dispatch out of DECODE; anything unsupported parks the core.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYP:      nxt = S_EXECUTER;
      OP_ITYP:      nxt = S_EXECUTEI;
      OP_BEQ:       nxt = S_BEQ;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_HALT;
    endcase
    return nxt;
  endfunction

  // ALU operation for R-type and I-type arithmetic. Subtraction needs both
  // the R-type opcode bit and instr[30]; addi with instr[30] set stays add.
  function automatic logic [2:0] alu_decode(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (op[5] & f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Immediate format selected purely from the opcode.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    return imm;
  endfunction

  state_t           state_q, state_d, state_next;
  logic [NBITS-1:0] instret_q, instret_d;
  logic             pc_w_raw, ir_w_raw, reg_w_raw, mem_w_raw;
  logic             we_allow;

  // Per-state next state, mux selects and ungated write enables.
  always_comb begin
    state_next = state_q;
    pc_w_raw   = 1'b0;
    ir_w_raw   = 1'b0;
    reg_w_raw  = 1'b0;
    mem_w_raw  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_w_raw  = mem_ready;
        pc_w_raw  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        state_next = decode_next(opcode);
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_w_raw  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_decode(opcode, funct3, funct7b5);
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(opcode, funct3, funct7b5);
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_w_raw  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_SUB;
        ResultSrc  = RES_ALUOUT;
        pc_w_raw   = Zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        pc_w_raw   = 1'b1;
        state_next = S_ALUWB;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      // Unused encodings are treated like an unsupported instruction.
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  // Write enables are suppressed while frozen or held in reset; selects are not.
  always_comb begin
    we_allow = enable & reset;
    PCWrite  = pc_w_raw  & we_allow;
    IRWrite  = ir_w_raw  & we_allow;
    RegWrite = reg_w_raw & we_allow;
    MemWrite = mem_w_raw & we_allow;
    ImmSrc   = imm_decode(opcode);
  end

  // Reset beats enable; a frozen FSM keeps its state and counter.
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    if (!reset) begin
      state_d   = S_FETCH;
      instret_d = '0;
    end else if (enable) begin
      state_d = state_next;
      if (IRWrite) instret_d = instret_q + NBITS'(1);
    end
  end

  // State and retired-instruction registers.
  always_ff @(posedge clock) begin
    state_q   <= state_d;
    instret_q <= instret_d;
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM with hand-computed state sequences and control values.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset, enable;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       halted;
  logic [7:0] instret;
  logic [3:0] we;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign we = {PCWrite, IRWrite, RegWrite, MemWrite};

  multicycle_control #(.NBITS(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .state(state), .halted(halted), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    #1;
  endtask

  // From FETCH: run one beq and check the branch decision.
  task automatic run_beq(input logic z, input logic exp_pc, input string tag);
    set_instr(7'b1100011, 3'b000, 1'b0);
    Zero = z;
    step();
    chk({tag, "_dec"}, 32'(state), 1);
    step();
    chk({tag, "_st"}, 32'(state), 9);
    chk({tag, "_pcw"}, 32'(PCWrite), 32'(exp_pc));
    chk({tag, "_alu"}, 32'(ALUControl), 1);
    chk({tag, "_imm"}, 32'(ImmSrc), 2);
    step();
    chk({tag, "_back"}, 32'(state), 0);
  endtask

  // From FETCH: run one ALU instruction and check the decoded operation.
  task automatic run_alu(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input int exp_st, input int exp_alu,
                         input string tag);
    set_instr(op, f3, f7);
    step();
    step();
    chk({tag, "_st"}, 32'(state), 32'(exp_st));
    chk({tag, "_alu"}, 32'(ALUControl), 32'(exp_alu));
    step();
    chk({tag, "_wb"}, 32'(RegWrite), 1);
    step();
    chk({tag, "_back"}, 32'(state), 0);
  endtask

  int seq_r [4] = '{0, 1, 6, 8};

  initial begin
    reset = 1'b0; enable = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_instret", 32'(instret), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_halted", 32'(halted), 0);

    // R-type add stream
    reset = 1'b1;
    #1;
    chk("fetch_irw", 32'(IRWrite), 1);
    chk("fetch_srcb", 32'(ALUSrcB), 2);
    chk("fetch_res", 32'(ResultSrc), 2);
    for (int i = 0; i < 12; i++) begin
      chk("add_seq", 32'(state), 32'(seq_r[i % 4]));
      chk("add_regw", 32'(RegWrite), (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 2) chk("add_alu", 32'(ALUControl), 0);
      step();
    end
    chk("add_instret", 32'(instret), 3);
    chk("add_state", 32'(state), 0);

    // lw with two wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    chk("lw_f_adr", 32'(AdrSrc), 0);
    step();
    chk("lw_dec", 32'(state), 1);
    chk("lw_dec_srca", 32'(ALUSrcA), 1);
    step();
    chk("lw_madr", 32'(state), 2);
    chk("lw_madr_srca", 32'(ALUSrcA), 2);
    chk("lw_madr_alu", 32'(ALUControl), 0);
    mem_ready = 1'b0;
    step();
    chk("lw_rd0", 32'(state), 3);
    chk("lw_rd_adr", 32'(AdrSrc), 1);
    chk("lw_rd_we", 32'(we), 0);
    step();
    chk("lw_rd1", 32'(state), 3);
    step();
    chk("lw_rd2", 32'(state), 3);
    mem_ready = 1'b1;
    step();
    chk("lw_wb", 32'(state), 4);
    chk("lw_wb_regw", 32'(RegWrite), 1);
    chk("lw_wb_res", 32'(ResultSrc), 1);
    step();
    chk("lw_back", 32'(state), 0);
    chk("lw_instret", 32'(instret), 4);

    // beq taken / not taken
    run_beq(1'b1, 1'b1, "beq_t");
    run_beq(1'b0, 1'b0, "beq_nt");
    Zero = 1'b0;

    // ALU decode
    run_alu(7'b0110011, 3'b000, 1'b1, 6, 1, "sub");
    run_alu(7'b0010011, 3'b000, 1'b1, 7, 0, "addi30");
    run_alu(7'b0110011, 3'b111, 1'b0, 6, 2, "and");
    run_alu(7'b0110011, 3'b110, 1'b0, 6, 3, "or");
    run_alu(7'b0110011, 3'b010, 1'b0, 6, 5, "slt");
    chk("alu_instret", 32'(instret), 11);

    // sw frozen in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    chk("sw_imm", 32'(ImmSrc), 1);
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("sw_st", 32'(state), 5);
    chk("sw_memw", 32'(MemWrite), 1);
    chk("sw_adr", 32'(AdrSrc), 1);
    step();
    chk("sw_wait", 32'(state), 5);
    enable = 1'b0; mem_ready = 1'b1;
    #1;
    chk("sw_frz_memw", 32'(MemWrite), 0);
    chk("sw_frz_adr", 32'(AdrSrc), 1);
    step();
    chk("sw_frz_st0", 32'(state), 5);
    step();
    chk("sw_frz_st1", 32'(state), 5);
    chk("sw_frz_inst", 32'(instret), 12);
    enable = 1'b1;
    #1;
    chk("sw_res_memw", 32'(MemWrite), 1);
    step();
    chk("sw_back", 32'(state), 0);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    chk("jal_imm", 32'(ImmSrc), 3);
    step();
    step();
    chk("jal_st", 32'(state), 10);
    chk("jal_pcw", 32'(PCWrite), 1);
    chk("jal_srca", 32'(ALUSrcA), 1);
    chk("jal_srcb", 32'(ALUSrcB), 2);
    step();
    chk("jal_wb", 32'(state), 8);
    step();
    chk("jal_back", 32'(state), 0);
    chk("jal_instret", 32'(instret), 13);

    // reset while in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("swr_st", 32'(state), 5);
    reset = 1'b0;
    #1;
    chk("swr_memw", 32'(MemWrite), 0);
    step();
    chk("swr_state", 32'(state), 0);
    chk("swr_instret", 32'(instret), 0);
    reset = 1'b1; mem_ready = 1'b1;

    // unsupported opcode halts
    set_instr(7'h7F, 3'b000, 1'b0);
    step();
    chk("halt_dec", 32'(state), 1);
    step();
    chk("halt_st", 32'(state), 15);
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", 32'(halted), 1);
      chk("halt_we", 32'(we), 0);
      chk("halt_hold", 32'(state), 15);
      step();
    end
    chk("halt_instret", 32'(instret), 1);
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
    #1;
    chk("unhalt_st", 32'(state), 0);
    chk("unhalt_inst", 32'(instret), 0);
    chk("unhalt_flag", 32'(halted), 0);

    // counter wrap with beq (3 cycles each)
    set_instr(7'b1100011, 3'b000, 1'b0);
    for (int i = 0; i < 255; i++) begin
      step();
      step();
      step();
    end
    chk("wrap_255", 32'(instret), 255);
    chk("wrap_st", 32'(state), 0);
    step();
    step();
    step();
    chk("wrap_0", 32'(instret), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
